// File: rtl/program_loader_pkg.sv
// program_loader_pkg: shared widths, loader state encoding and the NOP word.
package program_loader_pkg;
    localparam int ADDR_W = 4;
    localparam int INSTR_W = 8;
    localparam int NIB_W = 4;
    localparam logic [INSTR_W-1:0] NOP = 8'h00;
    typedef enum logic [1:0] {
        ST_RUN = 2'd0,
        ST_LOAD_HI = 2'd1,
        ST_LOAD_LO = 2'd2,
        ST_FINISH = 2'd3
    } state_e;
endpackage

// File: rtl/program_loader_if.sv
// program_loader_if: user load port plus CPU fetch/hold signals of the loader.
interface program_loader_if;
    import program_loader_pkg::*;
    logic load_en;
    logic nib_valid;
    logic [NIB_W-1:0] nib_data;
    logic nib_ready;
    logic [ADDR_W-1:0] pc_addr;
    logic [INSTR_W-1:0] instr;
    logic cpu_hold;
    logic load_done;
    logic [ADDR_W-1:0] wr_addr;
    modport master (
        output load_en, nib_valid, nib_data, pc_addr,
        input nib_ready, instr, cpu_hold, load_done, wr_addr
    );
    modport slave (
        input load_en, nib_valid, nib_data, pc_addr,
        output nib_ready, instr, cpu_hold, load_done, wr_addr
    );
endinterface

// File: rtl/program_rom_16x8.sv
// program_rom_16x8: register-array program store, sync write, registered read.
module program_rom_16x8
    import program_loader_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic we,
    input  logic rd_clr,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [INSTR_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [INSTR_W-1:0] rd_data
);
    logic [INSTR_W-1:0] mem_q [2**ADDR_W];
    logic [INSTR_W-1:0] mem_d [2**ADDR_W];
    logic [INSTR_W-1:0] rd_q, rd_d;
    always_comb begin
        mem_d = mem_q;
        if (we) mem_d[wr_addr] = wr_data;
        rd_d = rd_clr ? NOP : mem_q[rd_addr];
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_q <= '{default: '0};
            rd_q <= '0;
        end else begin
            mem_q <= mem_d;
            rd_q <= rd_d;
        end
    end
    assign rd_data = rd_q;
endmodule

// File: rtl/program_loader.sv
// program_loader: loads the program store from nibble pairs while holding the CPU,
// otherwise serves registered instructions for the fetch address.
module program_loader
    import program_loader_pkg::*;
(
    input logic clock,
    input logic reset,
    program_loader_if.slave bus
);
    state_e state_q, state_d;
    logic load_en_q;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [NIB_W-1:0] hi_q, hi_d;
    logic cpu_hold_q, cpu_hold_d;
    logic start, we, rd_clr;
    always_comb begin
        start = bus.load_en & ~load_en_q;
        state_d = state_q;
        wr_addr_d = wr_addr_q;
        hi_d = hi_q;
        we = 1'b0;
        case (state_q)
            ST_RUN: if (start) begin
                state_d = ST_LOAD_HI;
                wr_addr_d = '0;
            end
            ST_LOAD_HI: if (!bus.load_en) begin
                state_d = ST_RUN;
                wr_addr_d = '0;
            end else if (bus.nib_valid) begin
                hi_d = bus.nib_data;
                state_d = ST_LOAD_LO;
            end
            ST_LOAD_LO: if (!bus.load_en) begin
                state_d = ST_RUN;
                wr_addr_d = '0;
            end else if (bus.nib_valid) begin
                we = 1'b1;
                state_d = (wr_addr_q == '1) ? ST_FINISH : ST_LOAD_HI;
                wr_addr_d = (wr_addr_q == '1) ? wr_addr_q : wr_addr_q + 1'b1;
            end
            ST_FINISH: begin
                state_d = ST_RUN;
                wr_addr_d = '0;
            end
            default: state_d = ST_RUN;
        endcase
        cpu_hold_d = state_d != ST_RUN;
        // instr reads NOP from the start edge until the first RUN cycle
        rd_clr = (state_q != ST_RUN) | start;
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_RUN;
            load_en_q <= 1'b0;
            wr_addr_q <= '0;
            hi_q <= '0;
            cpu_hold_q <= 1'b0;
        end else begin
            state_q <= state_d;
            load_en_q <= bus.load_en;
            wr_addr_q <= wr_addr_d;
            hi_q <= hi_d;
            cpu_hold_q <= cpu_hold_d;
        end
    end
    program_rom_16x8 u_rom (
        .clock(clock),
        .reset(reset),
        .we(we),
        .rd_clr(rd_clr),
        .wr_addr(wr_addr_q),
        .wr_data({hi_q, bus.nib_data}),
        .rd_addr(bus.pc_addr),
        .rd_data(bus.instr)
    );
    assign bus.nib_ready = (state_q == ST_LOAD_HI) | (state_q == ST_LOAD_LO);
    assign bus.load_done = state_q == ST_FINISH;
    assign bus.cpu_hold = cpu_hold_q;
    assign bus.wr_addr = wr_addr_q;
endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Writer side of the CPU instruction-fetch interface: a 16-word x 8-bit program store, loaded from the 4-bit user input as high/low nibble pairs and read by the program counter address.
- While loading, holds the CPU (cpu_hold) so registers and PC stay frozen.
- When not loading, serves instr for the current pc_addr with one-cycle latency.
- Sits between the top-level user I/O and the fetch path of the 4-bit CPU core.

Parameters:
ADDR_W, 4, address width; depth = 2**ADDR_W
INSTR_W, 8, instruction width (opcode nibble + immediate nibble)
NIB_W, 4, load-port data width; INSTR_W must equal 2*NIB_W

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
load_en  input  1  load request; rising edge starts a load, low aborts
nib_valid  input  1  nib_data valid this cycle
nib_data  input  NIB_W  program nibble, high nibble first
nib_ready  output  1  loader accepts a nibble this cycle
pc_addr  input  ADDR_W  fetch address from program counter
instr  output  INSTR_W  registered instruction for pc_addr
cpu_hold  output  1  high while loading; CPU must not advance
load_done  output  1  one-cycle pulse after the last word is written
wr_addr  output  ADDR_W  current load address (status/debug)

Behaviour:
- Reset (async, immediate):
  - state=RUN; all memory words, instr, wr_addr and the hi-nibble register = 0.
  - cpu_hold=0, nib_ready=0, load_done=0.
- States: RUN, LOAD_HI, LOAD_LO, FINISH.
- load_en edge detection:
  - load_en is registered each cycle.
  - start = load_en & ~load_en_q.
  - load_en held high across the end of a load does not restart a load.
- RUN:
  - Each cycle instr <= mem[pc_addr]; latency 1 cycle from pc_addr change.
  - On start: go to LOAD_HI, wr_addr <= 0, cpu_hold <= 1.
- LOAD_HI:
  - nib_ready=1.
  - If nib_valid, capture nib_data into hi and go to LOAD_LO.
- LOAD_LO:
  - nib_ready=1.
  - If nib_valid: mem[wr_addr] <= {hi, nib_data}.
  - If wr_addr == 2**ADDR_W-1, go to FINISH. Otherwise wr_addr increments and state returns to LOAD_HI.
- FINISH:
  - load_done=1 for exactly one cycle.
  - Next cycle go to RUN; cpu_hold <= 0, wr_addr <= 0.
- Transfer rule: a nibble transfers only when nib_valid & nib_ready on the same clock edge. nib_valid while nib_ready=0 is ignored.
- Abort: load_en low in LOAD_HI or LOAD_LO takes priority over nib_valid that cycle.
  - Go to RUN; cpu_hold <= 0; load_done stays 0.
  - Words already written keep new values, remaining words keep old values.
  - A pending high nibble is discarded.
- instr while cpu_hold=1: forced to 0 (NOP) and updated from memory again the first RUN cycle.
- start while not in RUN: ignored.
- Wrap-around: wr_addr never wraps inside a load; the last word always leads to FINISH.
- cpu_hold is registered, with no combinational path from load_en.
- Reset mid-load: everything returns to reset values immediately, including memory contents.

Decomposition:
- Shared package holds:
  - ADDR_W/INSTR_W/NIB_W defaults.
  - State encoding constants ST_RUN=2'd0, ST_LOAD_HI=2'd1, ST_LOAD_LO=2'd2, ST_FINISH=2'd3.
  - The NOP instruction constant 8'h00.
- One sub-module: program_rom_16x8.
  - Register array with synchronous write port and registered read port, async clear.
  - The loader FSM instantiates it.

Test Plan:
- Reset during activity -> instr=0, cpu_hold=0, nib_ready=0, load_done=0, and mem[any] reads 0 one cycle after RUN.
- Full load: pulse load_en, feed 32 nibbles where word i = {i, ~i} -> cpu_hold=1 throughout, load_done pulses once after 32nd transfer, then pc_addr=5 gives instr=8'h5A next cycle.
- Gapped valid: nib_valid toggling every other cycle -> same memory image as continuous feed, no duplicated or dropped nibbles.
- Abort: load_en low after word 3's high nibble -> RUN next cycle, cpu_hold=0, words 0-2 new, word 3 and above unchanged, load_done never pulses.
- load_en held high after FINISH -> no second load, cpu_hold stays 0; a later low-then-high edge starts a load with wr_addr=0.
- Fetch latency: pc_addr sweeps 0..15 in RUN -> instr matches mem[pc_addr] exactly one cycle later; during a load instr stays 8'h00.
